// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   A load strobe captures a packed digit word and per-digit decimal points.
//   One digit is shown per refresh slot. Every slot starts with a short window
//   in which all anodes are off, so the previous digit does not ghost onto the
//   next one. Leading zeros can be suppressed, and codes 10-15 can be shown as
//   hex glyphs.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   enable     1 = scanning, 0 = display dark and scan counters held at zero
//   load       single-cycle strobe that captures digits_in / dp_in
//   digits_in  packed 4-bit codes, [3:0] = digit 0 (least significant)
//   dp_in      decimal point request per digit, 1 = lit
//   blank_lz   1 = suppress leading zeros (sampled live)
//   seg        {g,f,e,d,c,b,a}, active-low, registered
//   dp         decimal point, active-low, registered
//   an         anode enables, active-low, at most one low, registered
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [RW-1:0] RcntLast = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] BlankEnd = RW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IdxLast  = IW'(NUM_DIGITS - 1);
    localparam logic          HexOn    = (HEX_MODE != 0);

    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic [RW-1:0]           rcnt_q, rcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    upper_zero;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = HexOn ? 7'b0001000 : 7'b1111111;
            4'hB:    g = HexOn ? 7'b0000011 : 7'b1111111;
            4'hC:    g = HexOn ? 7'b1000110 : 7'b1111111;
            4'hD:    g = HexOn ? 7'b0100001 : 7'b1111111;
            4'hE:    g = HexOn ? 7'b0000110 : 7'b1111111;
            default: g = HexOn ? 7'b0001110 : 7'b1111111;
        endcase
        return g;
    endfunction

    // Scan counters: slot counter plus digit index, both cleared while disabled.
    always_comb begin
        rcnt_d = rcnt_q;
        idx_d  = idx_q;
        if (!enable) begin
            rcnt_d = '0;
            idx_d  = '0;
        end else if (rcnt_q == RcntLast) begin
            rcnt_d = '0;
            idx_d  = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end else begin
            rcnt_d = rcnt_q + 1'b1;
        end
    end

    // Select the current digit and find whether it and every more significant
    // digit are zero (the leading-zero condition).
    always_comb begin
        cur_code   = 4'h0;
        cur_dp     = 1'b0;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code = shadow_q[4*i +: 4];
                cur_dp   = shadow_dp_q[i];
            end
            if (IW'(i) >= idx_q && shadow_q[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    // Output next-state is built from the pre-edge counters, so the pins lag
    // the counters by exactly one cycle.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (enable && rcnt_q >= BlankEnd) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_d[i] = (idx_q != IW'(i));
            end
            dp_d = ~cur_dp;
            // Suppressed digits keep their anode and decimal point.
            if (blank_lz && idx_q != '0 && upper_zero) begin
                seg_d = 7'h7F;
            end else begin
                seg_d = glyph(cur_code);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            rcnt_q      <= '0;
            idx_q       <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= '1;
        end else begin
            if (load) begin
                shadow_q    <= digits_in;
                shadow_dp_q <= dp_in;
            end
            rcnt_q <= rcnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a HEX_MODE=1 and a HEX_MODE=0 instance share
// stimulus. Each step pushes the expected outputs of a cycle model onto a
// scoreboard, advances one clock and pops/compares. Directed checks with
// literal glyph values are layered on top.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic        clk = 1'b0;
    logic        rst_n, enable, load, blank_lz;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg_hx, seg_dc;
    logic        dp_hx, dp_dc;
    logic [3:0]  an_hx, an_dc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [6:0] seg_h;
        logic [6:0] seg_d;
        logic       dp;
        logic [3:0] an;
    } exp_t;
    exp_t sb[$];

    // Cycle model state
    int         m_sh[ND];
    logic [3:0] m_dp;
    int         m_rcnt, m_idx;

    // Directed scan expectations per digit
    logic [6:0] want_h[ND];
    logic [6:0] want_d[ND];
    logic [3:0] want_dp;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_hx), .dp(dp_hx), .an(an_hx)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HEX_MODE(0)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg_dc), .dp(dp_dc), .an(an_dc)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_glyph(int code, bit hex);
        case (code)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return hex ? 7'b0001000 : 7'b1111111;
            11: return hex ? 7'b0000011 : 7'b1111111;
            12: return hex ? 7'b1000110 : 7'b1111111;
            13: return hex ? 7'b0100001 : 7'b1111111;
            14: return hex ? 7'b0000110 : 7'b1111111;
            default: return hex ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    task automatic check(string name, logic [6:0] obs, logic [6:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    // One clock: push model expectation, update model, clock, pop and compare.
    task automatic step();
        exp_t e;
        bit   sup;
        if (!rst_n || !enable || m_rcnt < BC) begin
            e.seg_h = 7'h7F;
            e.seg_d = 7'h7F;
            e.dp    = 1'b1;
            e.an    = 4'hF;
        end else begin
            sup = blank_lz && (m_idx > 0);
            for (int j = m_idx; j < ND; j++) if (m_sh[j] != 0) sup = 1'b0;
            e.seg_h = sup ? 7'h7F : ref_glyph(m_sh[m_idx], 1'b1);
            e.seg_d = sup ? 7'h7F : ref_glyph(m_sh[m_idx], 1'b0);
            e.dp    = ~m_dp[m_idx];
            e.an    = ~(4'b0001 << m_idx);
        end
        sb.push_back(e);

        if (!rst_n) begin
            for (int j = 0; j < ND; j++) m_sh[j] = 0;
            m_dp   = 4'h0;
            m_rcnt = 0;
            m_idx  = 0;
        end else begin
            if (load) begin
                for (int j = 0; j < ND; j++) m_sh[j] = int'(digits_in[4*j +: 4]);
                m_dp = dp_in;
            end
            if (!enable) begin
                m_rcnt = 0;
                m_idx  = 0;
            end else if (m_rcnt == RD - 1) begin
                m_rcnt = 0;
                m_idx  = (m_idx + 1) % ND;
            end else begin
                m_rcnt++;
            end
        end

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("seg_hex", seg_hx, e.seg_h);
        check("seg_dec", seg_dc, e.seg_d);
        check("dp_hex", {6'b0, dp_hx}, {6'b0, e.dp});
        check("dp_dec", {6'b0, dp_dc}, {6'b0, e.dp});
        check("an_hex", {3'b0, an_hx}, {3'b0, e.an});
        check("an_dec", {3'b0, an_dc}, {3'b0, e.an});
    endtask

    task automatic do_load(logic [15:0] d, logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    // Drop enable for one cycle so the scan restarts at digit 0, rcnt 0.
    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    // Walk one full frame and compare against the directed want_* tables.
    task automatic check_scan(string tag);
        logic [3:0] an_exp;
        for (int s = 0; s < ND; s++) begin
            step();
            check({tag, "_blank_an"}, {3'b0, an_hx}, 7'h0F);
            check({tag, "_blank_seg"}, seg_hx, 7'h7F);
            an_exp = ~(4'b0001 << s);
            for (int k = 0; k < RD - BC; k++) begin
                step();
                check({tag, "_an"}, {3'b0, an_hx}, {3'b0, an_exp});
                check({tag, "_seg_hex"}, seg_hx, want_h[s]);
                check({tag, "_seg_dec"}, seg_dc, want_d[s]);
                check({tag, "_dp"}, {6'b0, dp_hx}, {6'b0, want_dp[s]});
            end
        end
    endtask

    initial begin
        for (int j = 0; j < ND; j++) m_sh[j] = 0;
        m_dp      = 4'h0;
        m_rcnt    = 0;
        m_idx     = 0;

        // Reset dominates load and enable
        rst_n     = 1'b0;
        enable    = 1'b1;
        load      = 1'b1;
        blank_lz  = 1'b0;
        digits_in = 16'hFFFF;
        dp_in     = 4'hF;
        step();
        step();
        check("rst_an", {3'b0, an_hx}, 7'h0F);
        check("rst_seg", seg_hx, 7'h7F);
        check("rst_dp", {6'b0, dp_hx}, 7'h01);
        rst_n = 1'b1;
        load  = 1'b0;
        step();
        check("rel_c1_an", {3'b0, an_hx}, 7'h0F);
        step();
        check("rel_c2_an", {3'b0, an_hx}, 7'h0E);
        check("rel_c2_seg", seg_hx, 7'b1000000);

        // Plain scan with a decimal point on digit 2
        do_load(16'h1234, 4'b0100);
        restart();
        want_h[0] = 7'b0011001; want_h[1] = 7'b0110000;
        want_h[2] = 7'b0100100; want_h[3] = 7'b1111001;
        want_d    = want_h;
        want_dp   = 4'b1011;
        check_scan("scan");
        step();
        check("wrap_blank", {3'b0, an_hx}, 7'h0F);
        step();
        check("wrap_an", {3'b0, an_hx}, 7'h0E);

        // Leading-zero suppression
        blank_lz = 1'b1;
        do_load(16'h0042, 4'b0000);
        restart();
        want_h[0] = 7'b0100100; want_h[1] = 7'b0011001;
        want_h[2] = 7'h7F;      want_h[3] = 7'h7F;
        want_d    = want_h;
        want_dp   = 4'hF;
        check_scan("lz42");
        do_load(16'h0000, 4'b0000);
        restart();
        want_h[0] = 7'b1000000; want_h[1] = 7'h7F;
        want_h[2] = 7'h7F;      want_h[3] = 7'h7F;
        want_d    = want_h;
        check_scan("lz00");

        // Hex glyphs vs blanked codes
        blank_lz = 1'b0;
        do_load(16'hABCD, 4'b0000);
        restart();
        want_h[0] = 7'b0100001; want_h[1] = 7'b1000110;
        want_h[2] = 7'b0000011; want_h[3] = 7'b0001000;
        for (int s = 0; s < ND; s++) want_d[s] = 7'h7F;
        check_scan("hex");

        // Mid-slot load and enable drop
        do_load(16'h0005, 4'b0000);
        restart();
        step();
        step();
        check("mid_pre_seg", seg_hx, 7'b0010010);
        digits_in = 16'h5678;
        load      = 1'b1;
        step();
        load      = 1'b0;
        check("mid_old_seg", seg_hx, 7'b0010010);
        step();
        check("mid_new_seg", seg_hx, 7'b0000000);
        check("mid_new_an", {3'b0, an_hx}, 7'h0E);
        step();
        step();
        check("d1_an", {3'b0, an_hx}, 7'h0D);
        check("d1_seg", seg_hx, 7'b1111000);
        enable = 1'b0;
        step();
        check("dis_an", {3'b0, an_hx}, 7'h0F);
        check("dis_seg", seg_hx, 7'h7F);
        enable = 1'b1;
        step();
        check("reen_blank", {3'b0, an_hx}, 7'h0F);
        step();
        check("reen_an", {3'b0, an_hx}, 7'h0E);
        check("reen_seg", seg_hx, 7'b0000000);

        // Reset mid-scan at idx 2, rcnt 3
        for (int k = 0; k < 9; k++) step();
        check("pos_an", {3'b0, an_hx}, 7'h0B);
        check("pos_seg", seg_hx, 7'b0000010);
        rst_n = 1'b0;
        step();
        check("mrst_an", {3'b0, an_hx}, 7'h0F);
        check("mrst_seg", seg_hx, 7'h7F);
        check("mrst_dp", {6'b0, dp_hx}, 7'h01);
        rst_n = 1'b1;
        step();
        step();
        check("post_an", {3'b0, an_hx}, 7'h0E);
        check("post_seg", seg_hx, 7'b1000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
